// File: rtl/apb_led_pkg.sv
// Shared types and constants for the APB LED-slave arbiter.
package apb_led_pkg;

  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Register indices of the apb_led_ctl slave
  localparam logic [1:0] LED  = 2'd0;
  localparam logic [1:0] RGBA = 2'd1;
  localparam logic [1:0] RGBB = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last_gnt=1 after reset so port 0 wins first.
module rr_arb2
  import apb_led_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_gnt;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_gnt <= 1'b1;
    else if (advance && (|gnt))
      last_gnt <= gnt[1];
  end

endmodule

// File: rtl/apb_led_arb.sv
// Two-port APB master sharing the LED register slave between game logic and host.
// state  | meaning
// IDLE   | no transfer; arbitrate pending requests
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready or timeout
module apb_led_arb
  import apb_led_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  wr0,
  input  logic [1:0]            addr0,
  input  logic [7:0]            wdata0,
  output logic                  done0,
  output logic                  err0,
  input  logic                  req1,
  input  logic                  wr1,
  input  logic [1:0]            addr1,
  input  logic [7:0]            wdata1,
  output logic                  done1,
  output logic                  err1,
  output logic [7:0]            rdata,
  output logic [31:0]           paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [APB_DATA_W-1:0] pwdata,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_t            state_q, state_d;
  logic                  gsel_q, gsel_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  psel_d, penable_d, pwrite_d;
  logic [31:0]           paddr_d;
  logic [APB_DATA_W-1:0] pwdata_d;
  logic [7:0]            rdata_d;
  logic                  done0_d, done1_d, err0_d, err1_d;
  logic [1:0]            gnt;
  logic                  advance, finish, fin_err;
  logic                  sel_wr;
  logic [1:0]            sel_addr;
  logic [7:0]            sel_wdata;
  logic                  unused_prdata;

  assign unused_prdata = ^prdata[APB_DATA_W-1:8];

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1, req0}),
    .advance (advance),
    .gnt     (gnt)
  );

  assign sel_wr    = gnt[1] ? wr1    : wr0;
  assign sel_addr  = gnt[1] ? addr1  : addr0;
  assign sel_wdata = gnt[1] ? wdata1 : wdata0;

  always_comb begin
    state_d   = state_q;
    gsel_d    = gsel_q;
    cnt_d     = cnt_q;
    psel_d    = psel;
    penable_d = penable;
    pwrite_d  = pwrite;
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    rdata_d   = rdata;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    fin_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          advance  = 1'b1;
          gsel_d   = gnt[1];
          psel_d   = 1'b1;
          pwrite_d = sel_wr;
          paddr_d  = BASE_ADDR + {28'h0, sel_addr, 2'b00};
          pwdata_d = {{(APB_DATA_W-8){1'b0}}, sel_wdata};
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = 16'd0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          finish  = 1'b1;
          fin_err = pslverr;
          rdata_d = pwrite ? 8'h00 : prdata[7:0];
        end else if ((TIMEOUT != 0) && (cnt_q == 16'(TIMEOUT - 1))) begin
          // Slave never answered: abandon the transfer and flag an error
          finish  = 1'b1;
          fin_err = 1'b1;
          rdata_d = 8'h00;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        if (finish) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          done0_d   = ~gsel_q;
          done1_d   = gsel_q;
          err0_d    = ~gsel_q & fin_err;
          err1_d    = gsel_q & fin_err;
          state_d   = IDLE;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gsel_q  <= 1'b0;
      cnt_q   <= 16'd0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= 32'h0;
      pwdata  <= '0;
      rdata   <= 8'h00;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
    end else begin
      state_q <= state_d;
      gsel_q  <= gsel_d;
      cnt_q   <= cnt_d;
      psel    <= psel_d;
      penable <= penable_d;
      pwrite  <= pwrite_d;
      paddr   <= paddr_d;
      pwdata  <= pwdata_d;
      rdata   <= rdata_d;
      done0   <= done0_d;
      done1   <= done1_d;
      err0    <= err0_d;
      err1    <= err1_d;
    end
  end

endmodule

// File: tb/tb_apb_led_arb.sv
// Directed bench for apb_led_arb with a hand-driven APB slave.
module tb_apb_led_arb;
  import apb_led_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, wr0, req1, wr1;
  logic [1:0]  addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        done0, err0, done1, err1;
  logic [7:0]  rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  apb_led_arb #(.BASE_ADDR(BASE), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .done0(done0), .err0(err0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .done1(done1), .err1(err1),
    .rdata(rdata), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h0;
    #12;
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_pwrite", pwrite, 1'b0);
    chk("rst_done", {done1, done0}, 2'b00);
    chk("rst_err", {err1, err0}, 2'b00);
    chk("rst_paddr", paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_rdata", rdata, 8'h00);
    rst = 1'b1;
    step();

    // zero-wait write from port 0
    req0 = 1; wr0 = 1; addr0 = RGBA; wdata0 = 8'h5A;
    step();
    chk("t1_setup_psel", psel, 1'b1);
    chk("t1_setup_penable", penable, 1'b0);
    chk("t1_paddr", paddr, BASE + 32'h4);
    chk("t1_pwrite", pwrite, 1'b1);
    chk("t1_pwdata", pwdata, 32'h5A);
    step();
    chk("t1_access", {psel, penable}, 2'b11);
    step();
    chk("t1_done0", done0, 1'b1);
    chk("t1_err0", err0, 1'b0);
    chk("t1_done1", done1, 1'b0);
    chk("t1_psel_drop", {psel, penable}, 2'b00);
    req0 = 0;
    step();
    chk("t1_done_pulse", done0, 1'b0);
    chk("t1_idle_psel", psel, 1'b0);

    // read from port 1
    prdata = 32'hFFFF_FF3C;
    req1 = 1; wr1 = 0; addr1 = RGBB; wdata1 = 8'hEE;
    step();
    chk("t2_paddr", paddr, BASE + 32'h8);
    chk("t2_pwrite", pwrite, 1'b0);
    chk("t2_psel", psel, 1'b1);
    step();
    step();
    chk("t2_done1", done1, 1'b1);
    chk("t2_err1", err1, 1'b0);
    chk("t2_rdata", rdata, 8'h3C);
    chk("t2_done0", done0, 1'b0);
    req1 = 0;
    step();

    // contention: both held, expect 0,1,0,1
    req0 = 1; wr0 = 1; addr0 = LED;   wdata0 = 8'h11;
    req1 = 1; wr1 = 1; addr1 = 2'd3;  wdata1 = 8'h22;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_paddr", paddr, (k % 2 == 1) ? BASE + 32'hC : BASE);
      chk("t3_pwdata", pwdata, (k % 2 == 1) ? 32'h22 : 32'h11);
      step();
      step();
      chk("t3_done0", done0, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk("t3_done1", done1, (k % 2 == 1) ? 1'b1 : 1'b0);
      if (k == 3) begin
        req0 = 0; req1 = 0;
      end
    end
    step();
    chk("t3_idle", psel, 1'b0);

    // wait states then slave error on a read
    pready = 0; prdata = 32'h0000_0096;
    req0 = 1; wr0 = 0; addr0 = 2'd3; wdata0 = 8'hA5;
    step();
    chk("t4_setup_penable", penable, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_paddr", paddr, BASE + 32'hC);
      chk("t4_pwdata", pwdata, 32'hA5);
      chk("t4_pwrite", pwrite, 1'b0);
      chk("t4_penable", {psel, penable}, 2'b11);
      if (i == 3) begin
        pready = 1; pslverr = 1;
      end
    end
    step();
    chk("t4_done0", done0, 1'b1);
    chk("t4_err0", err0, 1'b1);
    chk("t4_rdata", rdata, 8'h96);
    chk("t4_penable_drop", penable, 1'b0);
    req0 = 0; pslverr = 0;
    step();

    // timeout after 16 ACCESS cycles
    pready = 0; prdata = 32'h0000_0055;
    req0 = 1; wr0 = 0; addr0 = RGBA;
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      chk("t5_access", {psel, penable}, 2'b11);
    end
    step();
    chk("t5_done0", done0, 1'b1);
    chk("t5_err0", err0, 1'b1);
    chk("t5_rdata", rdata, 8'h00);
    chk("t5_psel_drop", psel, 1'b0);
    req0 = 0; pready = 1;
    step();
    prdata = 32'h0000_0042;
    req0 = 1; wr0 = 0; addr0 = RGBB;
    step();
    chk("t5_next_paddr", paddr, BASE + 32'h8);
    step();
    step();
    chk("t5_next_done0", done0, 1'b1);
    chk("t5_next_err0", err0, 1'b0);
    chk("t5_next_rdata", rdata, 8'h42);
    req0 = 0;
    step();

    // reset asserted mid-ACCESS
    pready = 0;
    req0 = 1; wr0 = 1; addr0 = LED; wdata0 = 8'h77;
    step();
    step();
    chk("t6_in_access", penable, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_drop", {psel, penable}, 2'b00);
    req0 = 0; pready = 1;
    step();
    step();
    chk("t6_no_done", {done1, done0}, 2'b00);
    rst = 1'b1;
    step();
    chk("t6_no_done_after", {done1, done0}, 2'b00);
    req0 = 1; wr0 = 0; addr0 = RGBA;
    req1 = 1; wr1 = 0; addr1 = RGBB;
    step();
    chk("t6_port0_first", paddr, BASE + 32'h4);
    step();
    step();
    chk("t6_done", {done1, done0}, 2'b01);
    req0 = 0; req1 = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
